cb_vm_agd_mc: RTL and testbench
===============================

Name: cb_vm_agd_mc

Overview:
Multi-channel covariance-block (CB) row address generator for the EKF-SLAM datapath.
- Per group it computes the group interval from group_cnt.
- It emits a handshaked burst of row addresses, one address per CB bank channel.
- It then advances a persistent base address by the interval, wrapping at a programmable CB limit.
- It sits between the group-level controller (start/done) and the CB bank read/write ports.

Parameters:
CB_AW, 17, CB address width per channel
ROW_LEN, 10, width of group_cnt
GRP_SHIFT, 3, log2 of the group row pitch (8 rows per group pair)
NUM_CH, 4, number of bank channels emitted in parallel
CH_STRIDE, 32768, address offset between adjacent channels
ROW_STRIDE, 1, address increment between consecutive rows of a burst
CB_MAX_ADDR, 131071, highest legal base address; the base wraps above it

Ports:
clk  in  1  clock
sys_rst  in  1  synchronous active-high reset
user_reset  in  1  synchronous soft clear: base to 0, abort any operation
start  in  1  single-cycle request; sampled only in IDLE
group_cnt  in  ROW_LEN  group index; sampled with start
row_num  in  8  rows to emit this group; sampled with start
ready  in  1  downstream accepts the current address beat
busy  out  1  high in every state except IDLE
addr_valid  out  1  CB_addr is valid
addr_last  out  1  marks the final beat of a burst
CB_addr  out  NUM_CH*CB_AW  channel k occupies bits [k*CB_AW +: CB_AW]
CB_base_addr  out  CB_AW  current base address
done  out  1  one-cycle pulse after the base update

Behaviour:
- Reset (sys_rst): all outputs are 0, FSM goes to IDLE, base is 0, internal registers are cleared.
- FSM states: IDLE, CALC, EMIT, UPDATE, DONE.
- IDLE, start=1: latch group_cnt and row_num, set row_ptr=0, go to CALC. start in any other state is ignored.
- CALC (1 cycle): interval = ((group_cnt>>1)<<GRP_SHIFT) + (1<<GRP_SHIFT) + group_cnt[0], computed at CB_AW width.
  - If row_num==0, go to UPDATE; otherwise go to EMIT.
- EMIT:
  - addr_valid=1.
  - Channel k address = (base + row_ptr*ROW_STRIDE + k*CH_STRIDE) mod 2^CB_AW.
  - addr_last=1 when row_ptr == row_num-1.
  - On valid&ready: row_ptr increments. If that beat was the last, go to UPDATE.
  - While ready=0: CB_addr, addr_valid and addr_last hold stable.
- UPDATE (1 cycle):
  - sum = base + interval, computed at CB_AW+1 bits.
  - If sum > CB_MAX_ADDR, base <= sum - (CB_MAX_ADDR+1); otherwise base <= sum.
  - addr_valid=0.
- DONE: done=1 for one cycle, then go to IDLE.
- CB_base_addr changes only in UPDATE, sys_rst, or user_reset.
- Latency:
  - start at cycle T: busy rises at T+1; first addr_valid at T+2.
  - With ready held high, the last beat is at T+1+row_num, the new base is visible at T+3+row_num, and done is at T+3+row_num.
  - With row_num==0: base updates at T+3, done at T+3.
- user_reset: acts in the next cycle from any state. Base and row_ptr go to 0, FSM goes to IDLE, addr_valid, busy and done are 0. No done is emitted for an aborted group.
- user_reset and start in the same cycle: user_reset wins and start is dropped.
- sys_rst has priority over user_reset.
- Channel addresses wrap modulo 2^CB_AW; only the base observes CB_MAX_ADDR.

Test Plan:
- Defaults, base=0, start with group_cnt=5, row_num=3, ready=1 -> interval 25. Beats at T+2..T+4: ch0 = 0,1,2; ch1 = 32768,32769,32770; ch3 = 98304..98306. addr_last on the 3rd beat; CB_base_addr=25 at T+6; done at T+6.
- Then group_cnt=2, row_num=1 -> interval 16. Single beat with ch0=25, addr_last=1. Base becomes 41, done pulses once.
- ready toggled 1,0,0,1 during a row_num=2 burst -> second address held stable for 2 stalled cycles. Exactly 2 accepted beats; done follows the final UPDATE.
- CB_MAX_ADDR=99, base=90, group_cnt=0 -> interval 8, base becomes 98. Next group_cnt=1 -> interval 9, sum 107, base wraps to 7.
- row_num=0, group_cnt=4 -> no addr_valid. Interval 24 applied, done at T+3.
- user_reset during EMIT beat 2 of 4 -> next cycle addr_valid=0, busy=0, base=0, no done. start raised together with user_reset is ignored; a later start proceeds from base 0.

Source files
------------

// File: rtl/cb_vm_agd_mc_if.sv
// Bus bundle for the covariance-block row address generator.
// master: group controller / CB bank side (drives start, group_cnt, row_num, ready)
// slave : the address generator (drives busy, addr_valid, addr_last, CB_addr,
//         CB_base_addr, done)
`timescale 1ns/1ps
interface cb_vm_agd_mc_if #(
  parameter int CB_AW   = 17,
  parameter int ROW_LEN = 10,
  parameter int NUM_CH  = 4
);
  logic                     start;
  logic [ROW_LEN-1:0]       group_cnt;
  logic [7:0]               row_num;
  logic                     ready;
  logic                     busy;
  logic                     addr_valid;
  logic                     addr_last;
  logic [NUM_CH*CB_AW-1:0]  CB_addr;
  logic [CB_AW-1:0]         CB_base_addr;
  logic                     done;

  modport master (
    output start, group_cnt, row_num, ready,
    input  busy, addr_valid, addr_last, CB_addr, CB_base_addr, done
  );

  modport slave (
    input  start, group_cnt, row_num, ready,
    output busy, addr_valid, addr_last, CB_addr, CB_base_addr, done
  );
endinterface

// File: rtl/cb_vm_agd_mc.sv
// Multi-channel covariance-block row address generator.
// Per group: derives the group interval from group_cnt, emits a handshaked
// burst of row addresses (one per bank channel, in parallel), then advances
// a persistent base address by the interval, wrapping above CB_MAX_ADDR.
// Ports:
//   clk, sys_rst (sync, active high), user_reset (sync soft clear)
//   bus.start/group_cnt/row_num : group request, sampled in IDLE
//   bus.ready                   : downstream accepts current beat
//   bus.busy/addr_valid/addr_last/CB_addr : burst outputs
//   bus.CB_base_addr, bus.done  : running base and completion pulse
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | compute group interval from latched group_cnt
// EMIT   | present row addresses, advance on valid & ready
// UPDATE | add interval to base, wrap above CB_MAX_ADDR
// DONE   | one-cycle done pulse
`timescale 1ns/1ps
module cb_vm_agd_mc #(
  parameter int CB_AW       = 17,
  parameter int ROW_LEN     = 10,
  parameter int GRP_SHIFT   = 3,
  parameter int NUM_CH      = 4,
  parameter int CH_STRIDE   = 32768,
  parameter int ROW_STRIDE  = 1,
  parameter int CB_MAX_ADDR = 131071
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          user_reset,
  cb_vm_agd_mc_if.slave bus
);

  localparam int SW     = CB_AW + 1;
  localparam int AW_ALL = NUM_CH * CB_AW;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_EMIT, S_UPDATE, S_DONE} state_t;

  state_t             state;
  logic [ROW_LEN-1:0] grp_q;
  logic [7:0]         rows_q;
  logic [7:0]         row_ptr;
  logic [7:0]         ptr_nxt;
  logic [CB_AW-1:0]   base;
  logic [CB_AW-1:0]   interval;
  logic [CB_AW-1:0]   interval_calc;
  logic [SW-1:0]      sum;
  logic               busy_q;
  logic               valid_q;
  logic               last_q;
  logic               done_q;
  logic [AW_ALL-1:0]  addr_q;

  // All channel addresses for one row; channel offsets wrap at 2^CB_AW.
  function automatic logic [AW_ALL-1:0] chan_addrs(input logic [CB_AW-1:0] b,
                                                   input logic [7:0]       p);
    logic [AW_ALL-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      v[k*CB_AW +: CB_AW] = b + CB_AW'(p) * CB_AW'(ROW_STRIDE) + CB_AW'(k * CH_STRIDE);
    end
    return v;
  endfunction

  always_comb begin
    interval_calc = (CB_AW'(grp_q >> 1) << GRP_SHIFT)
                  + (CB_AW'(1) << GRP_SHIFT)
                  + CB_AW'(grp_q[0]);
    // One extra bit so the wrap compare sees the carry out of base + interval.
    sum     = {1'b0, base} + {1'b0, interval};
    ptr_nxt = row_ptr + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (sys_rst || user_reset) begin
      // sys_rst and user_reset clear the same state; sys_rst simply also
      // covers the case where both are asserted.
      state    <= S_IDLE;
      grp_q    <= '0;
      rows_q   <= '0;
      row_ptr  <= '0;
      base     <= '0;
      interval <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            grp_q   <= bus.group_cnt;
            rows_q  <= bus.row_num;
            row_ptr <= '0;
            busy_q  <= 1'b1;
            state   <= S_CALC;
          end
        end

        S_CALC: begin
          interval <= interval_calc;
          if (rows_q == 8'd0) begin
            state <= S_UPDATE;
          end else begin
            // First beat is prepared here so addr_valid is registered.
            addr_q  <= chan_addrs(base, 8'd0);
            valid_q <= 1'b1;
            last_q  <= (rows_q == 8'd1);
            state   <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (bus.ready) begin
            row_ptr <= ptr_nxt;
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              addr_q  <= '0;
              state   <= S_UPDATE;
            end else begin
              addr_q <= chan_addrs(base, ptr_nxt);
              last_q <= (ptr_nxt == rows_q - 8'd1);
            end
          end
        end

        S_UPDATE: begin
          // A single subtraction is enough while base <= CB_MAX_ADDR and the
          // interval does not exceed the CB span.
          if (sum > SW'(CB_MAX_ADDR)) begin
            base <= CB_AW'(sum - SW'(CB_MAX_ADDR + 1));
          end else begin
            base <= CB_AW'(sum);
          end
          done_q <= 1'b1;
          state  <= S_DONE;
        end

        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.addr_valid   = valid_q;
  assign bus.addr_last    = last_q;
  assign bus.CB_addr      = addr_q;
  assign bus.CB_base_addr = base;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_cb_vm_agd_mc.sv
`timescale 1ns/1ps
module tb_cb_vm_agd_mc;

  localparam int CB_AW  = 17;
  localparam int NUM_CH = 4;
  localparam int AWA    = CB_AW * NUM_CH;

  logic       clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       user_reset = 1'b0;
  logic       start = 1'b0;
  logic [9:0] group_cnt = '0;
  logic [7:0] row_num = '0;
  logic       ready = 1'b0;

  always #5 clk = ~clk;

  cb_vm_agd_mc_if #(.CB_AW(CB_AW), .ROW_LEN(10), .NUM_CH(NUM_CH)) if_a ();
  cb_vm_agd_mc_if #(.CB_AW(CB_AW), .ROW_LEN(10), .NUM_CH(NUM_CH)) if_b ();

  assign if_a.start = start;  assign if_a.group_cnt = group_cnt;
  assign if_a.row_num = row_num;  assign if_a.ready = ready;
  assign if_b.start = start;  assign if_b.group_cnt = group_cnt;
  assign if_b.row_num = row_num;  assign if_b.ready = ready;

  cb_vm_agd_mc dut_a (.clk(clk), .sys_rst(sys_rst), .user_reset(user_reset), .bus(if_a));
  cb_vm_agd_mc #(.CB_MAX_ADDR(99)) dut_b (.clk(clk), .sys_rst(sys_rst),
                                          .user_reset(user_reset), .bus(if_b));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: one base per instance, different wrap limits.
  int maxv  [2] = '{131071, 99};
  int mbase [2] = '{0, 0};
  logic [AWA:0]     q_beat [2][$];
  logic [CB_AW-1:0] q_base [2][$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int interval_of(input int g);
    return (g / 2) * 8 + 8 + (g % 2);
  endfunction

  // Expected beats and new base for one group, for both instances.
  task automatic model_group(input int g, input int r);
    for (int d = 0; d < 2; d++) begin
      int s;
      for (int p = 0; p < r; p++) begin
        logic [AWA:0] bt;
        bt = '0;
        for (int k = 0; k < NUM_CH; k++)
          bt[k*CB_AW +: CB_AW] = CB_AW'((mbase[d] + p + k * 32768) % 131072);
        bt[AWA] = (p == r - 1);
        q_beat[d].push_back(bt);
      end
      s = mbase[d] + interval_of(g);
      mbase[d] = (s > maxv[d]) ? (s - (maxv[d] + 1)) % 131072 : s;
      q_base[d].push_back(CB_AW'(mbase[d]));
    end
  endtask

  // Monitor: pops expected beats/bases whenever a DUT presents output.
  logic            prev_stall [2] = '{1'b0, 1'b0};
  logic [AWA:0]    prev_beat  [2];

  always @(negedge clk) begin
    if (!sys_rst) begin
      for (int d = 0; d < 2; d++) begin
        logic v, l, dn;
        logic [AWA-1:0] a;
        logic [CB_AW-1:0] b;
        logic [AWA:0] e;
        v  = (d == 0) ? if_a.addr_valid : if_b.addr_valid;
        l  = (d == 0) ? if_a.addr_last  : if_b.addr_last;
        dn = (d == 0) ? if_a.done       : if_b.done;
        a  = (d == 0) ? if_a.CB_addr    : if_b.CB_addr;
        b  = (d == 0) ? if_a.CB_base_addr : if_b.CB_base_addr;
        if (prev_stall[d])
          check($sformatf("stall_hold%0d", d), {v, l, a}, {1'b1, prev_beat[d]});
        if (v && ready) begin
          if (q_beat[d].size() == 0) begin
            n_checks++;
            $display("FAIL extra_beat%0d: got addr %0h expected no beat", d, a);
          end else begin
            e = q_beat[d].pop_front();
            check($sformatf("beat%0d", d), {l, a}, e);
          end
        end
        if (dn) begin
          if (q_base[d].size() == 0) begin
            n_checks++;
            $display("FAIL extra_done%0d: got done expected none", d);
          end else begin
            check($sformatf("base%0d", d), b, q_base[d].pop_front());
          end
        end
        prev_stall[d] = v && !ready;
        prev_beat[d]  = {l, a};
      end
    end
  end

  // mode 0: ready held high; 1: random ready; 2: ready 1,0,0,1 then high
  task automatic run_group(input int g, input int r, input int mode);
    bit pat[$];
    int ones, exp_lat, c;
    bit seen;
    ones = 0;
    while (ones < r) begin
      bit b;
      if (mode == 0) b = 1'b1;
      else if (mode == 2) b = (pat.size() == 0 || pat.size() >= 3);
      else b = ($urandom_range(0, 3) != 0);
      pat.push_back(b);
      if (b) ones++;
    end
    exp_lat = (r == 0) ? 3 : 4 + (pat.size() - 1);
    model_group(g, r);

    start = 1'b1; group_cnt = 10'(g); row_num = 8'(r); ready = 1'b0;
    check("idle_busy", if_a.busy, 1'b0);
    step();
    start = 1'b0;
    check("busy_rise", if_a.busy, 1'b1);
    c = 1; seen = 1'b0;
    while (!seen && c < exp_lat + 20) begin
      step();
      c++;
      ready = (c - 2 < pat.size()) ? pat[c - 2] : 1'b0;
      if (c == 2) check("first_valid", if_a.addr_valid, (r != 0));
      if (if_a.done) begin
        seen = 1'b1;
        check("done_latency", c, exp_lat);
      end
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", exp_lat + 20);
    end
    ready = 1'b0;
    step();
  endtask

  task automatic flush_model();
    for (int d = 0; d < 2; d++) begin
      q_beat[d].delete();
      q_base[d].delete();
      mbase[d] = 0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    step(); step(); step();
    check("rst_a", {if_a.busy, if_a.addr_valid, if_a.addr_last, if_a.CB_addr,
                    if_a.CB_base_addr, if_a.done}, '0);
    check("rst_b", {if_b.busy, if_b.addr_valid, if_b.addr_last, if_b.CB_addr,
                    if_b.CB_base_addr, if_b.done}, '0);
    sys_rst = 1'b0;
    step();

    // Directed sequence; instance b reaches base 90 then wraps.
    run_group(5, 3, 0);   // base 25
    run_group(2, 1, 0);   // base 41
    run_group(4, 0, 0);   // base 65, no beats
    run_group(5, 2, 2);   // base 90, stalled burst
    run_group(0, 1, 0);   // base 98
    run_group(1, 0, 0);   // a: 107, b: wraps to 7
    check("wrap_b", if_b.CB_base_addr, 17'd7);
    check("nowrap_a", if_a.CB_base_addr, 17'd107);

    // Abort during beat 2 of 4; a start in the same cycle is dropped.
    model_group(3, 4);
    start = 1'b1; group_cnt = 10'd3; row_num = 8'd4; ready = 1'b1;
    step(); start = 1'b0;      // CALC
    step();                    // beat 1
    step();                    // beat 2
    user_reset = 1'b1; start = 1'b1;
    step();
    user_reset = 1'b0; start = 1'b0; ready = 1'b0;
    flush_model();
    check("abort_a", {if_a.addr_valid, if_a.busy, if_a.done, if_a.CB_base_addr}, '0);
    check("abort_b", {if_b.addr_valid, if_b.busy, if_b.done, if_b.CB_base_addr}, '0);
    repeat (6) step();

    // user_reset together with start while idle.
    start = 1'b1; group_cnt = 10'd7; row_num = 8'd2; user_reset = 1'b1;
    step();
    start = 1'b0; user_reset = 1'b0;
    check("ur_start_busy", if_a.busy, 1'b0);
    repeat (4) step();
    check("ur_start_idle", {if_a.busy, if_a.addr_valid}, '0);

    run_group(5, 3, 0);   // restarts from base 0 -> 25
    check("restart_base", if_a.CB_base_addr, 17'd25);

    for (int i = 0; i < 40; i++)
      run_group($urandom_range(0, 1023), $urandom_range(0, 12), (i % 3 == 0) ? 0 : 1);

    repeat (4) step();
    check("beats_drained", q_beat[0].size() + q_beat[1].size(), 0);
    check("bases_drained", q_base[0].size() + q_base[1].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
